spi_xfer_arbiter: RTL
=====================

Name: spi_xfer_arbiter

Overview:
- Sequences and shares the 32-bit SPI master core between two requesters over the core's 3-bit-address register port.
- For each granted request, the block:
  - writes the slave-select register,
  - writes the TX data register,
  - waits for the core's dataavailable,
  - reads RX data back and returns it with a one-cycle ack.
- Sits between the streaming clients and the SPI core, in place of CPU register traffic.

Parameters:
- DATA_W, 32, transfer and register data width.
- SS_W, 32, width of the slave-select mask written to register 5.
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks (used only with SPIARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a transfer pending; held until req0_ack.
- req0_wdata  in  DATA_W  requester 0 TX word; stable while req0_valid.
- req0_ss  in  SS_W  requester 0 slave-select mask.
- req0_ack  out  1  one-cycle pulse: transfer done, rdata/err valid.
- req1_valid, req1_wdata, req1_ss, req1_ack  as requester 0.
- rdata  out  DATA_W  RX word of the last completed transfer; held until the next ack.
- err  out  1  qualifies ack: transfer aborted (timeout build only; else constant 0).
- busy  out  1  high in every state except IDLE.
- spi_select  out  1  core chip select for a register access.
- mem_addr  out  3  core register address.
- data_from_cpu  out  DATA_W  core write data.
- write_n  out  1  core write strobe, active low.
- read_n  out  1  core read strobe, active low.
- data_to_cpu  in  DATA_W  core registered read data.
- dataavailable  in  1  core RRDY.
- readyfordata  in  1  core TRDY.

Behaviour:
- Reset values:
  - spi_select=0, write_n=1, read_n=1, mem_addr=0, data_from_cpu=0.
  - req*_ack=0, rdata=0, err=0, busy=1.
  - state=INIT, rr_last=1, so requester 0 wins the first tie.
- All outputs are registered.
- Every core access is exactly 2 clocks with spi_select=1, stable mem_addr/data, and write_n or read_n low.
- Each access is followed by at least 1 clock with spi_select=0, write_n=1, read_n=1. This guarantees exactly one core strobe per access.
- Read data is sampled from data_to_cpu on the clock after the 2nd access cycle.
- States:
  - INIT: 2-cycle write to addr 2 (data 0) clears stale status; -> IDLE.
  - IDLE: if any req*_valid, grant round-robin (the requester not granted last wins ties) and latch its wdata/ss; -> WR_SS. Otherwise stay.
  - WR_SS: write addr 5 with the latched ss; -> WR_DAT.
  - WR_DAT: wait for readyfordata=1, then write addr 1 with the latched wdata; -> WAIT_RX.
  - WAIT_RX: stay while dataavailable=0; -> RD_DAT on 1.
  - RD_DAT: read addr 0; capture into rdata; -> ACK.
  - ACK: pulse ack of the granted requester (err=0) for 1 cycle; update rr_last; -> IDLE.
- The granted requester's valid is not rechecked after IDLE. Dropping valid mid-transfer does not abort it; the ack is still issued.
- The non-granted requester waits. Its valid must stay asserted; no starvation, because it wins the next arbitration.
- Minimum idle-to-ack latency: 1 + 3 + 3 + core transfer (≈67) + 3 + 1 clocks.
- Back-to-back requests by the same requester: its valid is sampled in IDLE the cycle after ack, so the requester must hold the next request valid then.
- Reset mid-transfer returns the block to INIT; the core is reset by the same reset_n.

Optional Feature:
- SPIARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_RX. When it reaches TIMEOUT_CYCLES-1 without dataavailable, the block:
  - writes addr 2 (clear status),
  - returns ack with err=1 and rdata=0,
  - then goes to IDLE.
  The counter clears on entry to WAIT_RX.
- Undefined: no counter; err is tied 0; WAIT_RX waits indefinitely.

Test Plan:
- Reset, then req0_valid with wdata=0xA5A5_0F0F, ss=0x1, MISO loopback -> core sees writes addr2, addr5=0x1, addr1=0xA5A5_0F0F, read addr0; req0_ack pulses once; rdata=0xA5A5_0F0F; err=0.
- req0 and req1 asserted in the same cycle from reset -> req0 served first, then req1; with both held, the grant order alternates 0,1,0,1.
- Bus-protocol checker on the core port -> every access is 2 cycles, followed by ≥1 idle cycle; no write_n/read_n low with spi_select=0.
- readyfordata forced 0 for 20 cycles in WR_DAT -> the addr1 write is delayed exactly until readyfordata=1; no TOE in the core.
- req1 drops valid during WAIT_RX -> the transfer completes and req1_ack still pulses.
- SPIARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, dataavailable held 0 -> err=1 with ack at 16 cycles after WAIT_RX entry plus the status-clear write; the next request completes normally.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Two-requester sequencer for the SPI master core register port: INIT clears status, then each
// grant writes SS (addr 5) and TX (addr 1), waits for RRDY, reads RX (addr 0) and pulses ack.
// Optional build macro SPIARB_TIMEOUT_EN adds a WAIT_RX watchdog that aborts with err=1.
module spi_xfer_arbiter #(
  parameter int DATA_W         = 32,
  parameter int SS_W           = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [SS_W-1:0]   req0_ss,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [SS_W-1:0]   req1_ss,
  output logic              req1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              spi_select,
  output logic [2:0]        mem_addr,
  output logic [DATA_W-1:0] data_from_cpu,
  output logic              write_n,
  output logic              read_n,
  input  logic [DATA_W-1:0] data_to_cpu,
  input  logic              dataavailable,
  input  logic              readyfordata
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_SS, S_WR_DAT, S_WAIT_RX, S_RD_DAT, S_ACK, S_TO_CLR
  } state_e;

  localparam logic [2:0] ADDR_RXDATA = 3'd0;
  localparam logic [2:0] ADDR_TXDATA = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_SSMASK = 3'd5;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic              gnt_q, gnt_d;
  logic              rr_last_q, rr_last_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic              spi_select_q, spi_select_d;
  logic [2:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] data_from_cpu_q, data_from_cpu_d;
  logic              write_n_q, write_n_d;
  logic              read_n_q, read_n_d;
  logic              req0_ack_q, req0_ack_d;
  logic              req1_ack_q, req1_ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

`ifdef SPIARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Per-state description of the core access the shared access engine performs.
  logic              acc_en;
  logic              acc_go;
  logic              acc_wr;
  logic [2:0]        acc_addr;
  logic [DATA_W-1:0] acc_data;
  state_e            acc_next;
  logic              grant1;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned,
    // which is what keeps this block free of inferred latches.
    state_d         = state_q;
    step_d          = step_q;
    gnt_d           = gnt_q;
    rr_last_d       = rr_last_q;
    wdata_d         = wdata_q;
    ss_d            = ss_q;
    spi_select_d    = spi_select_q;
    mem_addr_d      = mem_addr_q;
    data_from_cpu_d = data_from_cpu_q;
    write_n_d       = write_n_q;
    read_n_d        = read_n_q;
    req0_ack_d      = req0_ack_q;
    req1_ack_d      = req1_ack_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    acc_en          = 1'b0;
    acc_go          = 1'b1;
    acc_wr          = 1'b1;
    acc_addr        = ADDR_RXDATA;
    acc_data        = '0;
    acc_next        = state_q;
    grant1          = req1_valid && (!req0_valid || !rr_last_q);
`ifdef SPIARB_TIMEOUT_EN
    wait_cnt_d      = '0;
`endif

    case (state_q)
      S_INIT: begin
        acc_en   = 1'b1;
        acc_addr = ADDR_STATUS;
        acc_next = S_IDLE;
      end
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = grant1;
          wdata_d = grant1 ? req1_wdata : req0_wdata;
          ss_d    = grant1 ? req1_ss : req0_ss;
          state_d = S_WR_SS;
        end
      end
      S_WR_SS: begin
        acc_en   = 1'b1;
        acc_addr = ADDR_SSMASK;
        acc_data = DATA_W'(ss_q);
        acc_next = S_WR_DAT;
      end
      S_WR_DAT: begin
        acc_en   = 1'b1;
        acc_go   = readyfordata;
        acc_addr = ADDR_TXDATA;
        acc_data = wdata_q;
        acc_next = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (dataavailable) begin
          state_d = S_RD_DAT;
        end
`ifdef SPIARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_TO_CLR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_RD_DAT: begin
        acc_en   = 1'b1;
        acc_wr   = 1'b0;
        acc_addr = ADDR_RXDATA;
        acc_next = S_ACK;
      end
`ifdef SPIARB_TIMEOUT_EN
      S_TO_CLR: begin
        acc_en   = 1'b1;
        acc_addr = ADDR_STATUS;
        acc_next = S_ACK;
      end
`endif
      S_ACK: begin
        req0_ack_d = 1'b0;
        req1_ack_d = 1'b0;
        rr_last_d  = gnt_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Access engine: step 0 idles (and waits for acc_go), steps 1-2 are the two strobe cycles.
    if (acc_en) begin
      case (step_q)
        2'd0: begin
          if (acc_go) begin
            spi_select_d    = 1'b1;
            mem_addr_d      = acc_addr;
            data_from_cpu_d = acc_data;
            write_n_d       = !acc_wr;
            read_n_d        = acc_wr;
            step_d          = 2'd1;
          end
        end
        2'd1: step_d = 2'd2;
        default: begin
          spi_select_d = 1'b0;
          write_n_d    = 1'b1;
          read_n_d     = 1'b1;
          step_d       = 2'd0;
          state_d      = acc_next;
          if (acc_next == S_ACK) begin
            req0_ack_d = !gnt_q;
            req1_ack_d = gnt_q;
            rdata_d    = (state_q == S_RD_DAT) ? data_to_cpu : '0;
`ifdef SPIARB_TIMEOUT_EN
            err_d      = (state_q == S_TO_CLR);
`else
            err_d      = 1'b0;
`endif
          end
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_INIT;
      step_q          <= 2'd0;
      gnt_q           <= 1'b0;
      rr_last_q       <= 1'b1;
      wdata_q         <= '0;
      ss_q            <= '0;
      spi_select_q    <= 1'b0;
      mem_addr_q      <= 3'd0;
      data_from_cpu_q <= '0;
      write_n_q       <= 1'b1;
      read_n_q        <= 1'b1;
      req0_ack_q      <= 1'b0;
      req1_ack_q      <= 1'b0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      busy_q          <= 1'b1;
`ifdef SPIARB_TIMEOUT_EN
      wait_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      gnt_q           <= gnt_d;
      rr_last_q       <= rr_last_d;
      wdata_q         <= wdata_d;
      ss_q            <= ss_d;
      spi_select_q    <= spi_select_d;
      mem_addr_q      <= mem_addr_d;
      data_from_cpu_q <= data_from_cpu_d;
      write_n_q       <= write_n_d;
      read_n_q        <= read_n_d;
      req0_ack_q      <= req0_ack_d;
      req1_ack_q      <= req1_ack_d;
      rdata_q         <= rdata_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
`ifdef SPIARB_TIMEOUT_EN
      wait_cnt_q      <= wait_cnt_d;
`endif
    end
  end

  assign req0_ack      = req0_ack_q;
  assign req1_ack      = req1_ack_q;
  assign rdata         = rdata_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign spi_select    = spi_select_q;
  assign mem_addr      = mem_addr_q;
  assign data_from_cpu = data_from_cpu_q;
  assign write_n       = write_n_q;
  assign read_n        = read_n_q;

endmodule
